pe16_axil_reg_slave: RTL and testbench

//  AXI4-Lite responder holding the PE16 block's control/data registers; the far end of the
//  BFM master used by the block testbench. Accepts single-beat writes/reads, returns OKAY
//  for mapped registers, SLVERR otherwise.

---
 rtl/pe16_axil_reg_slave.sv | 212 +++++++++++++++++++++
 tb/tb_pe16_axil_reg_slave.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe16_axil_reg_slave.sv
// -----------------------------------------------------------------------------
// pe16_axil_reg_slave
//
// AXI4-Lite responder for the PE16 block's control/data registers. It accepts
// single-beat writes and reads. Mapped registers return OKAY. Unmapped word
// indices return SLVERR; their reads return zero data and their writes change
// nothing. The register file and a one-cycle write-notify pulse are driven out
// to the PE16 array datapath.
//
// Ports
//   ACLK, ARESET         clock (rising edge) / asynchronous active-high reset
//   S_AXI_AW*            write address channel (AWPROT ignored)
//   S_AXI_W*             write data channel with byte strobes
//   S_AXI_B*             write response (00 OKAY, 10 SLVERR)
//   S_AXI_AR*            read address channel (ARPROT ignored)
//   S_AXI_R*             read data / response
//   regs_o               register file, reg i at [32*i +: 32]
//   wr_pulse_o           one-cycle pulse after each committed mapped write
//   wr_idx_o             register index of that write, valid with wr_pulse_o
// -----------------------------------------------------------------------------
module pe16_axil_reg_slave #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_NUM_REGS   = 4
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,
    input  logic [C_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]              S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]              S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [C_DATA_WIDTH*C_NUM_REGS-1:0]   regs_o,
    output logic                                 wr_pulse_o,
    output logic [((C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1)-1:0] wr_idx_o
);

    localparam int NB     = C_DATA_WIDTH / 8;
    localparam int AIDX_W = C_ADDR_WIDTH - 2;
    localparam int IDX_W  = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-side state
    logic                    r_aw_held;
    logic [AIDX_W-1:0]       r_aw_idx;
    logic                    r_w_held;
    logic [C_DATA_WIDTH-1:0] r_w_data;
    logic [NB-1:0]           r_w_strb;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_wr_pulse;
    logic [IDX_W-1:0]        r_wr_idx;

    // Read-side state
    logic                    r_rvalid;
    logic [1:0]              r_rresp;
    logic [C_DATA_WIDTH-1:0] r_rdata;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_ar_hs;
    logic                    w_commit;
    logic [AIDX_W-1:0]       w_wr_idx;
    logic [C_DATA_WIDTH-1:0] w_wr_data;
    logic [NB-1:0]           w_wr_strb;
    logic                    w_wr_mapped;
    logic [AIDX_W-1:0]       w_rd_idx;
    logic                    w_rd_mapped;
    logic [C_DATA_WIDTH-1:0] w_rd_data;
    logic [C_NUM_REGS-1:0][C_DATA_WIDTH-1:0] w_regs;
    logic                    w_unused;

    // Ready terms are gated by ARESET so every output is 0 while reset is held,
    // yet all three are high in the very first cycle after release.
    assign S_AXI_AWREADY = !ARESET && !r_aw_held && !r_bvalid;
    assign S_AXI_WREADY  = !ARESET && !r_w_held  && !r_bvalid;
    assign S_AXI_ARREADY = !ARESET && !r_rvalid;

    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Commit on the edge where the later of AW/W completes. Both flags can
    // never be held together, so one handshake must be live this cycle.
    assign w_commit = (w_aw_hs || r_aw_held) && (w_w_hs || r_w_held) && (w_aw_hs || w_w_hs);

    // Use the latched address/data when that half arrived earlier, else live.
    assign w_wr_idx  = r_aw_held ? r_aw_idx : S_AXI_AWADDR[C_ADDR_WIDTH-1:2];
    assign w_wr_data = r_w_held  ? r_w_data : S_AXI_WDATA;
    assign w_wr_strb = r_w_held  ? r_w_strb : S_AXI_WSTRB;

    // One extra bit so that C_NUM_REGS == 2^AIDX_W compares correctly.
    assign w_wr_mapped = {1'b0, w_wr_idx} < (AIDX_W+1)'(C_NUM_REGS);
    assign w_rd_idx    = S_AXI_ARADDR[C_ADDR_WIDTH-1:2];
    assign w_rd_mapped = {1'b0, w_rd_idx} < (AIDX_W+1)'(C_NUM_REGS);

    // Address byte-offset bits and PROT are don't-care for this slave.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Register file: one byte-strobed word per mapped index.
    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg
        logic [C_DATA_WIDTH-1:0] r_q;
        logic                    w_we;

        assign w_we = w_commit && (w_wr_idx == AIDX_W'(g));

        always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
                r_q <= '0;
            end else if (w_we) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_wr_strb[b]) r_q[8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end

        assign w_regs[g] = r_q;
    end

    assign regs_o = w_regs;

    // Write address/data holding and B channel
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_aw_held  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_held   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= 1'b0;
            r_wr_idx   <= '0;
        end else begin
            r_wr_pulse <= w_commit && w_wr_mapped;
            if (w_commit && w_wr_mapped) r_wr_idx <= IDX_W'(w_wr_idx);

            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= S_AXI_AWADDR[C_ADDR_WIDTH-1:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= S_AXI_WDATA;
                    r_w_strb <= S_AXI_WSTRB;
                end
            end

            // READY is low while BVALID is up, so commit and a pending
            // response never overlap; BRESP is left alone after the handshake.
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read mux; an unmapped index matches nothing and yields zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (w_rd_idx == AIDX_W'(i)) w_rd_data = w_regs[i];
        end
    end

    // R channel. RDATA is captured from the pre-edge register value, so a
    // same-edge write commit to the same register is not visible to this read.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
            r_rdata  <= w_rd_data;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RRESP  = r_rresp;
    assign S_AXI_RDATA  = r_rdata;
    assign wr_pulse_o   = r_wr_pulse;
    assign wr_idx_o     = r_wr_idx;

endmodule

// File: tb/tb_pe16_axil_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_pe16_axil_reg_slave
//
// Two slaves share one set of bus inputs: d4 has four registers and d3 has
// three, so index 3 (0xC) is unmapped on d3. Ready timing does not depend on
// mapping, so one handshake sequence serves both. Expected responses are
// queued when a request is issued and popped when the response appears.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pe16_axil_reg_slave;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  AWADDR = '0, ARADDR = '0;
    logic [2:0]  AWPROT = '0, ARPROT = '0;
    logic        AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;

    logic        awready4, wready4, bvalid4, arready4, rvalid4, pulse4;
    logic [1:0]  bresp4, rresp4, idx4;
    logic [31:0] rdata4;
    logic [127:0] regs4;
    logic        awready3, wready3, bvalid3, arready3, rvalid3, pulse3;
    logic [1:0]  bresp3, rresp3, idx3;
    logic [31:0] rdata3;
    logic [95:0] regs3;

    always #5 ACLK = ~ACLK;

    pe16_axil_reg_slave #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(4), .C_NUM_REGS(4)) d4 (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(awready4),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(wready4),
        .S_AXI_BRESP(bresp4), .S_AXI_BVALID(bvalid4), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(arready4),
        .S_AXI_RDATA(rdata4), .S_AXI_RRESP(rresp4), .S_AXI_RVALID(rvalid4), .S_AXI_RREADY(RREADY),
        .regs_o(regs4), .wr_pulse_o(pulse4), .wr_idx_o(idx4)
    );

    pe16_axil_reg_slave #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(4), .C_NUM_REGS(3)) d3 (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(awready3),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(wready3),
        .S_AXI_BRESP(bresp3), .S_AXI_BVALID(bvalid3), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(arready3),
        .S_AXI_RDATA(rdata3), .S_AXI_RRESP(rresp3), .S_AXI_RVALID(rvalid3), .S_AXI_RREADY(RREADY),
        .regs_o(regs3), .wr_pulse_o(pulse3), .wr_idx_o(idx3)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } rsp_t;

    rsp_t        qr4[$], qr3[$];
    logic [1:0]  qb4[$], qb3[$];
    logic [31:0] m4[4], m3[4];
    int n_assert = 0, n_fail = 0;
    int pc4 = 0, pc3 = 0;
    logic [1:0] li4 = '0, li3 = '0;

    // Pulse counters; they are read only on falling edges where no pulse is up.
    always @(negedge ACLK) begin
        if (pulse4) begin pc4++; li4 = idx4; end
        if (pulse3) begin pc3++; li3 = idx3; end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Queue the expected write responses and apply the write to the models.
    task automatic exp_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a[3:2]);
        qb4.push_back(2'b00);
        m4[idx] = merge(m4[idx], d, s);
        if (idx < 3) begin
            qb3.push_back(2'b00);
            m3[idx] = merge(m3[idx], d, s);
        end else begin
            qb3.push_back(2'b10);
        end
    endtask

    task automatic exp_read(input logic [3:0] a);
        int idx;
        rsp_t e;
        idx = int'(a[3:2]);
        e.d = m4[idx]; e.r = 2'b00;
        qr4.push_back(e);
        if (idx < 3) begin e.d = m3[idx]; e.r = 2'b00; end
        else         begin e.d = 32'h0;   e.r = 2'b10; end
        qr3.push_back(e);
    endtask

    // Wait for BVALID with BREADY already high; pop and compare the responses.
    task automatic wait_b(input string tag);
        logic [1:0] e4, e3;
        for (int c = 0; c < 20 && !bvalid4; c++) @(negedge ACLK);
        chk({tag, "_bvalid"}, bvalid4, 1);
        e4 = (qb4.size() > 0) ? qb4.pop_front() : 2'bxx;
        e3 = (qb3.size() > 0) ? qb3.pop_front() : 2'bxx;
        chk({tag, "_bresp4"}, bresp4, e4);
        chk({tag, "_bresp3"}, bresp3, e3);
        @(negedge ACLK);
    endtask

    task automatic wait_r(input string tag);
        rsp_t e4, e3;
        for (int c = 0; c < 20 && !rvalid4; c++) @(negedge ACLK);
        chk({tag, "_rvalid"}, rvalid4, 1);
        e4 = (qr4.size() > 0) ? qr4.pop_front() : 'x;
        e3 = (qr3.size() > 0) ? qr3.pop_front() : 'x;
        chk({tag, "_rdata4"}, rdata4, e4.d);
        chk({tag, "_rresp4"}, rresp4, e4.r);
        chk({tag, "_rdata3"}, rdata3, e3.d);
        chk({tag, "_rresp3"}, rresp3, e3.r);
        @(negedge ACLK);
    endtask

    task automatic do_write(input string tag, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_p, w_p;
        exp_write(a, d, s);
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1; WVALID = 1; BREADY = 1;
        for (int c = 0; c < 20 && (AWVALID || WVALID); c++) begin
            aw_p = AWVALID && awready4;
            w_p  = WVALID && wready4;
            @(negedge ACLK);
            if (aw_p) AWVALID = 0;
            if (w_p)  WVALID = 0;
        end
        AWVALID = 0; WVALID = 0;
        wait_b(tag);
        BREADY = 0;
    endtask

    task automatic do_read(input string tag, input logic [3:0] a);
        bit ar_p;
        exp_read(a);
        ARADDR = a; ARVALID = 1; RREADY = 1;
        for (int c = 0; c < 20 && ARVALID; c++) begin
            ar_p = arready4;
            @(negedge ACLK);
            if (ar_p) ARVALID = 0;
        end
        ARVALID = 0;
        wait_r(tag);
        RREADY = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_regs4"}, regs4, {m4[3], m4[2], m4[1], m4[0]});
        chk({tag, "_regs3"}, regs3, {m3[2], m3[1], m3[0]});
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_outs4"}, {awready4, wready4, bvalid4, bresp4, arready4, rvalid4, rresp4, rdata4, pulse4, idx4}, '0);
        chk({tag, "_outs3"}, {awready3, wready3, bvalid3, bresp3, arready3, rvalid3, rresp3, rdata3, pulse3, idx3}, '0);
        chk({tag, "_regs4"}, regs4, '0);
        chk({tag, "_regs3"}, regs3, '0);
    endtask

    initial begin
        int p4, p3;
        logic [3:0] addrs [4];
        logic [31:0] dats [4];
        addrs = '{4'h0, 4'h4, 4'h8, 4'hC};
        dats  = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
        for (int i = 0; i < 4; i++) begin m4[i] = '0; m3[i] = '0; end

        // Reset state
        #2;
        chk_outs_zero("rst");
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 0;
        #1;
        chk("rst_rel_ready4", {awready4, wready4, arready4}, 3'b111);
        chk("rst_rel_ready3", {awready3, wready3, arready3}, 3'b111);
        @(negedge ACLK);

        // Write all four words, read back; 0xC is unmapped on d3
        p3 = pc3;
        for (int i = 0; i < 4; i++) do_write("t1_wr", addrs[i], dats[i], 4'hF);
        chk("t1_pulses3", pc3 - p3, 3);
        for (int i = 0; i < 4; i++) do_read("t1_rd", addrs[i]);
        chk_regs("t1");

        // Unmapped write on d3: no pulse, registers untouched
        p3 = pc3;
        do_write("t5_wr", 4'hC, 32'h55AA55AA, 4'hF);
        chk("t5_nopulse3", pc3 - p3, 0);
        chk_regs("t5");
        do_read("t5_rd", 4'hC);

        // Partial strobe write, pulse and index
        do_write("t2_full", 4'h4, 32'hFFFFFFFF, 4'hF);
        p4 = pc4;
        do_write("t2_part", 4'h5, 32'h00001234, 4'b0011);
        chk("t2_pulse_cnt", pc4 - p4, 1);
        chk("t2_pulse_idx", li4, 2'd1);
        do_read("t2_rd", 4'h4);
        p4 = pc4;
        do_write("t2_zero_strb", 4'h4, 32'h0BAD0BAD, 4'b0000);
        chk("t2_zs_pulse", pc4 - p4, 1);
        do_read("t2_zs_rd", 4'h4);

        // W three cycles ahead of AW, BREADY held low for five cycles
        p4 = pc4;
        exp_write(4'h0, 32'h5A5A5A5A, 4'hF);
        AWADDR = 4'h0; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF;
        WVALID = 1; BREADY = 0;
        chk("t3_wready_idle", wready4, 1);
        @(negedge ACLK);
        WVALID = 0;
        for (int k = 0; k < 2; k++) begin
            chk("t3_wready_held", wready4, 0);
            chk("t3_awready_open", awready4, 1);
            chk("t3_no_bvalid", bvalid4, 0);
            @(negedge ACLK);
        end
        AWVALID = 1;
        @(negedge ACLK);
        AWVALID = 0;
        chk("t3_bresp_first", {bvalid4, bresp4}, {1'b1, qb4.pop_front()});
        void'(qb3.pop_front());
        for (int k = 0; k < 5; k++) begin
            chk("t3_b_hold", {bvalid4, bresp4, awready4, wready4}, 5'b1_00_00);
            if (k < 4) @(negedge ACLK);
        end
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
        chk("t3_after_b", {bvalid4, awready4, wready4}, 3'b011);
        chk("t3_pulse_cnt", pc4 - p4, 1);
        do_read("t3_rd", 4'h0);

        // Same-edge read and write commit on 0x8: read returns the old value
        exp_read(4'h8);
        exp_write(4'h8, 32'h12345678, 4'hF);
        AWADDR = 4'h8; WDATA = 32'h12345678; WSTRB = 4'hF; ARADDR = 4'h8;
        AWVALID = 1; WVALID = 1; ARVALID = 1; BREADY = 0; RREADY = 0;
        chk("t4_readies", {awready4, wready4, arready4}, 3'b111);
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        BREADY = 1;
        wait_b("t4_b");
        BREADY = 0;
        RREADY = 1;
        wait_r("t4_r_old");
        RREADY = 0;
        do_read("t4_r_new", 4'h8);

        // Reset while both BVALID and RVALID are pending
        AWADDR = 4'h4; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; ARADDR = 4'h0;
        AWVALID = 1; WVALID = 1; ARVALID = 1; BREADY = 0; RREADY = 0;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        chk("t6_pending", {bvalid4, rvalid4}, 2'b11);
        #2 ARESET = 1;
        #1;
        chk_outs_zero("t6_in_rst");
        @(negedge ACLK);
        chk_outs_zero("t6_in_rst_edge");
        ARESET = 0;
        #1;
        chk("t6_rel_ready4", {awready4, wready4, arready4, bvalid4, rvalid4}, 5'b11100);
        chk("t6_rel_ready3", {awready3, wready3, arready3, bvalid3, rvalid3}, 5'b11100);
        @(negedge ACLK);
        for (int i = 0; i < 4; i++) begin m4[i] = '0; m3[i] = '0; end
        for (int i = 0; i < 4; i++) do_read("t6_rd", addrs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
